// File: rtl/aes_v2_sub_size.sv
`default_nettype none
// ============================================================================
// Module   : aes_v2_sub_size
// Purpose  : Lightweight AES SubBytes/ShiftRows instruction unit. Collects
//            one byte per output lane from rs1/rs2 in a ShiftRows pattern,
//            then applies the forward (enc=1) or inverse (enc=0) AES S-box.
//            The S-box is built from GF(2^8) arithmetic, with no lookup ROM.
//            FAST=0 : one shared S-box, one byte per cycle, 4 cycles.
//            FAST=1 : four S-boxes in parallel, result in the same cycle.
// Ports    : clock, reset      - clock, synchronous active-high reset
//            flush, flush_data - restart; flush_data[23:0] preloads bytes
//            valid             - operands valid; held until ready
//            rs1, rs2          - source registers
//            enc               - 1 = forward S-box, 0 = inverse S-box
//            ready             - result valid this cycle
//            result            - substituted word
// Revision : 1.0 - initial release
// ============================================================================
module aes_v2_sub_size #(
  parameter int FAST = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_data,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11b).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254. The chain builds x^127 by repeated
  // square-and-multiply, and one more squaring gives x^254. Because 0^254 = 0,
  // inv(0) comes out as 0 with no special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    p = x;
    for (int i = 0; i < 6; i++) begin
      p = gf_mul(gf_mul(p, p), x);
    end
    return gf_mul(p, p);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
  endfunction

  // One inverter per S-box. The enc mux picks the stage that wraps it: the
  // inverse affine goes in front of the inverter for decrypt, and the forward
  // affine goes after it for encrypt.
  function automatic logic [7:0] sbox(input logic [7:0] x, input logic fwd);
    logic [7:0] pre;
    logic [7:0] inv;
    pre = fwd ? x : affine_inv(x);
    inv = gf_inv(pre);
    return fwd ? affine_fwd(inv) : inv;
  endfunction

  // ShiftRows-style lane gather.
  logic [7:0] lane [4];
  assign lane[0] = rs1[7:0];
  assign lane[1] = rs2[15:8];
  assign lane[2] = rs1[23:16];
  assign lane[3] = rs2[31:24];

  generate
    if (FAST != 0) begin : g_fast
      for (genvar i = 0; i < 4; i++) begin : g_lane
        // Gate the operand so the S-box logic does not toggle while idle.
        assign result[8*i +: 8] = sbox(lane[i] & {8{valid}}, enc);
      end
      assign ready = valid;

      logic unused_fast;
      assign unused_fast = ^{clock, reset, flush, flush_data};
    end else begin : g_seq
      typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

      state_t     fsm_q;
      logic [7:0] b0_q;
      logic [7:0] b1_q;
      logic [7:0] b2_q;
      logic       ready_q;
      logic [7:0] sel;
      logic [7:0] sub;

      // The FSM state doubles as the lane select for the shared S-box.
      always_comb begin
        sel = lane[fsm_q];
        sub = sbox(sel & {8{valid}}, enc);
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          fsm_q   <= S0;
          b0_q    <= 8'h00;
          b1_q    <= 8'h00;
          b2_q    <= 8'h00;
          ready_q <= 1'b0;
        end else if (flush) begin
          // A valid step in the same cycle is discarded. The bytes are
          // preloaded from flush_data, and bits [31:24] have no register.
          fsm_q              <= S0;
          {b2_q, b1_q, b0_q} <= flush_data[23:0];
          ready_q            <= 1'b0;
        end else if (valid) begin
          case (fsm_q)
            S0: begin
              b0_q  <= sub;
              fsm_q <= S1;
            end
            S1: begin
              b1_q  <= sub;
              fsm_q <= S2;
            end
            S2: begin
              b2_q    <= sub;
              fsm_q   <= S3;
              ready_q <= 1'b1;
            end
            default: begin
              // S3 holds with ready high until the next flush.
              fsm_q <= S3;
            end
          endcase
        end
      end

      assign ready  = ready_q;
      // In S3 the top byte comes straight from the shared S-box on lane 3.
      assign result = {sub, b2_q, b1_q, b0_q};

      logic unused_seq;
      assign unused_seq = ^flush_data[31:24];
    end
  endgenerate

endmodule
`default_nettype wire
